// File: rtl/spi_slave_buf.sv
// Buffered SPI mode-0 responder: oversamples the SPI pins in the clk domain,
// captures up to 128 MOSI bits left-aligned and shifts a preloaded word out on MISO.
module spi_slave_buf (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] slv_wfifo,
    input  logic         slv_ack,
    output logic [127:0] slv_rfifo,
    output logic [7:0]   slv_status,
    input  logic         scl,
    input  logic         ss,
    input  logic         mosi,
    output logic         miso
);

    localparam int unsigned DW  = 128;
    localparam int unsigned CW  = 8;
    localparam int unsigned BW  = 5;
    localparam int unsigned IW  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    scl_q;
    logic [2:0]    ss_q;
    logic [1:0]    mosi_q;

    logic          scl_rise;
    logic          scl_fall;
    logic          ss_rise;
    logic          ss_fall;

    logic          load_frame;
    logic          take_bit;
    logic          shift_tx;
    logic          commit;

    logic [DW-1:0] tx_sh;
    logic [DW-1:0] rx_buf;
    logic [CW-1:0] cnt;
    logic          cnt_full;
    logic [IW-1:0] wr_idx;
    logic          overrun;

    logic          busy;
    logic          rx_valid;
    logic          err;
    logic [BW-1:0] byte_cnt;

    // Pin synchronisers; all three paths share the same depth so MOSI stays aligned to SCL edges
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_q  <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            scl_q  <= {scl_q[1:0], scl};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign scl_rise =  scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] &  scl_q[2];
    assign ss_rise  =  ss_q[1]  & ~ss_q[2];
    assign ss_fall  = ~ss_q[1]  &  ss_q[2];

    assign cnt_full = cnt[CW-1];
    assign wr_idx   = IW'(7'd127 - cnt[IW-1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        load_frame = 1'b0;
        take_bit   = 1'b0;
        shift_tx   = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE:    load_frame = ss_fall;
            ACTIVE: begin
                take_bit = scl_rise;
                shift_tx = scl_fall;
            end
            DONE:    commit = 1'b1;
            default: ;
        endcase
    end

    // Transmit shifter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_sh <= '0;
        end else if (load_frame) begin
            tx_sh <= slv_wfifo;
        end else if (shift_tx) begin
            tx_sh <= {tx_sh[DW-2:0], 1'b0};
        end
    end

    // Receive buffer and bit counter; bits past 128 are dropped and flagged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_buf  <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (load_frame) begin
            rx_buf  <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (take_bit) begin
            if (!cnt_full) begin
                rx_buf[wr_idx] <= mosi_q[1];
                cnt            <= cnt + CW'(1);
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    // Frame results, published in the single DONE cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slv_rfifo <= '0;
            byte_cnt  <= '0;
            err       <= 1'b0;
        end else if (commit) begin
            slv_rfifo <= rx_buf;
            byte_cnt  <= cnt[CW-1:3];
            err       <= overrun | (|cnt[2:0]);
        end
    end

    // rx_valid: a commit beats a coincident ack
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_valid <= 1'b0;
        end else if (commit) begin
            rx_valid <= 1'b1;
        end else if (slv_ack) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= 1'b0;
        end else if (load_frame) begin
            busy <= 1'b1;
        end else if (commit) begin
            busy <= 1'b0;
        end
    end

    assign slv_status = {busy, rx_valid, err, byte_cnt};

    // MISO is gated off outside a frame and once the transmit word is exhausted
    assign miso = (state == ACTIVE) && !cnt_full && tx_sh[DW-1];

endmodule

// File: tb/tb_spi_slave_buf.sv
// Self-checking bench for spi_slave_buf: a bit-level SPI master drives frames and a
// frame-level reference model predicts received data, status and the MISO stream.
module tb_spi_slave_buf;

    logic         clk;
    logic         rstn;
    logic [127:0] slv_wfifo;
    logic         slv_ack;
    logic [127:0] slv_rfifo;
    logic [7:0]   slv_status;
    logic         scl;
    logic         ss;
    logic         mosi;
    logic         miso;

    int tests;
    int failed;

    // Reference model of the published results
    logic [127:0] m_rf;
    logic         m_valid;
    logic         m_err;
    logic [4:0]   m_cnt;

    spi_slave_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .slv_wfifo  (slv_wfifo),
        .slv_ack    (slv_ack),
        .slv_rfifo  (slv_rfifo),
        .slv_status (slv_status),
        .scl        (scl),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {1'b0, m_valid, m_err, m_cnt};
    endfunction

    task automatic ack_pulse(input string tag);
        @(negedge clk);
        slv_ack = 1'b1;
        @(negedge clk);
        slv_ack = 1'b0;
        m_valid = 1'b0;
        check({tag, " status"}, 256'(slv_status), 256'(m_status()));
    endtask

    // One SPI mode-0 frame of nbits bits taken MSB-first from mbits[255:...]
    task automatic run_frame(input string tag, input int nbits, input logic [255:0] mbits,
                             input logic [127:0] wf, input bit ack_in_done, input int rst_at);
        logic [255:0] sbits;
        logic [255:0] exp_s;
        logic [127:0] exp_rx;
        int           kept;
        bit           was_rst;
        sbits   = '0;
        exp_s   = '0;
        was_rst = 1'b0;
        @(negedge clk);
        slv_wfifo = wf;
        ss        = 1'b0;
        mosi      = mbits[255];
        repeat (6) @(negedge clk);
        check({tag, " busy_start"}, 256'(slv_status[7]), 256'(1'b1));
        for (int i = 0; i < nbits; i++) begin
            sbits[255-i] = miso;
            scl = 1'b1;
            repeat (5) @(negedge clk);
            scl = 1'b0;
            if (i + 1 < nbits) mosi = mbits[254-i];
            else               mosi = 1'b0;
            repeat (5) @(negedge clk);
            if (i + 1 == rst_at) begin
                rstn = 1'b0;
                repeat (2) @(negedge clk);
                rstn    = 1'b1;
                was_rst = 1'b1;
                m_rf    = '0;
                m_valid = 1'b0;
                m_err   = 1'b0;
                m_cnt   = '0;
                @(negedge clk);
                check({tag, " rst_status"}, 256'(slv_status), 256'(8'h00));
                check({tag, " rst_rfifo"},  256'(slv_rfifo),  256'(128'h0));
            end
        end
        ss = 1'b1;
        repeat (3) @(negedge clk);
        if (!was_rst) check({tag, " busy_hold"}, 256'(slv_status[7]), 256'(1'b1));
        if (ack_in_done) slv_ack = 1'b1;
        @(negedge clk);
        slv_ack = 1'b0;
        if (!was_rst) begin
            kept   = (nbits > 128) ? 128 : nbits;
            exp_rx = '0;
            for (int k = 0; k < kept; k++) exp_rx[127-k] = mbits[255-k];
            m_rf    = exp_rx;
            m_cnt   = 5'(kept / 8);
            m_err   = (nbits > 128) || (kept % 8 != 0);
            m_valid = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            if (was_rst && i >= rst_at) exp_s[255-i] = 1'b0;
            else if (i < 128)           exp_s[255-i] = wf[127-i];
            else                        exp_s[255-i] = 1'b0;
        end
        check({tag, " rfifo"},  256'(slv_rfifo),  256'(m_rf));
        check({tag, " status"}, 256'(slv_status), 256'(m_status()));
        check({tag, " miso"},   sbits,            exp_s);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [255:0] mb;
        logic [127:0] wf;
        int           nb;
        tests     = 0;
        failed    = 0;
        rstn      = 1'b0;
        slv_wfifo = '0;
        slv_ack   = 1'b0;
        scl       = 1'b0;
        ss        = 1'b1;
        mosi      = 1'b0;
        m_rf      = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_cnt     = '0;

        repeat (3) @(negedge clk);
        check("reset status", 256'(slv_status), 256'(8'h00));
        check("reset rfifo",  256'(slv_rfifo),  256'(128'h0));
        check("reset miso",   256'(miso),       256'(1'b0));
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("full16", 128, {{16{8'h5a}}, 128'h0}, {4{32'hDEADBEEF}}, 1'b0, -1);
        check("full16 status_const", 256'(slv_status), 256'(8'h50));
        ack_pulse("ack");
        check("ack status_const", 256'(slv_status), 256'(8'h10));

        run_frame("short6", 48, {{6{8'h5a}}, 208'h0}, {4{32'hDEADBEEF}}, 1'b0, -1);
        check("short6 status_const", 256'(slv_status), 256'(8'h46));

        run_frame("overrun", 136, {{17{8'hA5}}, 120'h0}, {4{32'h3C96_F00F}}, 1'b0, -1);
        check("overrun status_const", 256'(slv_status), 256'(8'h70));

        run_frame("partial", 12, {12'hABC, 244'h0}, {4{32'h1234_5678}}, 1'b0, -1);
        check("partial status_const", 256'(slv_status), 256'(8'h61));

        run_frame("abort", 0, 256'h0, {4{32'hFFFF_FFFF}}, 1'b0, -1);
        check("abort status_const", 256'(slv_status), 256'(8'h40));

        ack_pulse("ack2");
        run_frame("ack_in_done", 16, {16'hC3E1, 240'h0}, {4{32'h8001_7FFE}}, 1'b1, -1);
        ack_pulse("ack3");

        run_frame("reset_mid", 128, {{16{8'h77}}, 128'h0}, {4{32'hDEADBEEF}}, 1'b0, 24);
        run_frame("after_rst", 128, {{16{8'h5a}}, 128'h0}, {4{32'hDEADBEEF}}, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) mb[k*32 +: 32] = $urandom();
            for (int k = 0; k < 4; k++) wf[k*32 +: 32] = $urandom();
            nb = int'($urandom_range(1, 140));
            run_frame($sformatf("rand%0d", r), nb, mb, wf, ($urandom_range(0, 3) == 0), -1);
            if ($urandom_range(0, 1) == 1) ack_pulse($sformatf("rand_ack%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
